assoc_mem_module: RTL

//  Parametrised successor to the direct-mapped memory module. It is a 2-way set-associative, write-back, write-allocate cache with LRU replacement in front of a handshaked backing RAM.

---
 rtl/assoc_mem_module.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/assoc_mem_module.sv
// 2-way set-associative write-back/write-allocate cache with LRU, indirect addressing and flush, in front of a handshaked RAM.
// Latency: hit 2 cycles start-to-dataReady; clean read miss 3 + RAM wait; dirty victim adds EVICT wait + 1; indirect adds a pass + 1.
// Backpressure: one command in flight; start ignored while busy; RAM requests held stable until ramReady.
module assoc_mem_module #(
  parameter int ramWidth = 8,
  parameter int addrSize = 8,
  parameter int indexW   = 2,
  parameter int cntW     = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [1:0]          cntrl,
  input  logic                isIndirect,
  input  logic [addrSize-1:0] addr,
  input  logic [ramWidth-1:0] dataIn,
  output logic [ramWidth-1:0] dataOut,
  output logic                dataReady,
  output logic                busy,
  output logic                ramRdEn,
  output logic                ramWrEn,
  output logic [addrSize-1:0] ramAddr,
  output logic [ramWidth-1:0] ramWData,
  input  logic [ramWidth-1:0] ramRData,
  input  logic                ramReady,
  output logic [cntW-1:0]     hitCount,
  output logic [cntW-1:0]     missCount
);
  localparam int numSets = 1 << indexW;
  localparam int tagW    = addrSize - indexW;
  localparam logic [1:0] cmdWrite = 2'b10;
  localparam logic [1:0] cmdFlush = 2'b11;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESOLVE, DONE, FLSCAN, FLWB} stateT;
  stateT state, nextState;

  logic [tagW-1:0]     tagArr   [2][numSets];
  logic [ramWidth-1:0] dataArr  [2][numSets];
  logic                validArr [2][numSets];
  logic                dirtyArr [2][numSets];
  logic                lruArr   [numSets];   // way to replace next

  logic [1:0]          opCmd;
  logic [addrSize-1:0] opAddr;
  logic [ramWidth-1:0] opData;
  logic                ptrPhase;   // current pass is the pointer fetch of an indirect op
  logic [addrSize-1:0] ptrVal;
  logic                victimWay;
  logic [indexW:0]     scanIdx;    // {set, way}, way in the LSB so way0 precedes way1

  logic [indexW-1:0]   idx;
  logic [tagW-1:0]     tagIn;
  logic                hit0, hit1, hit, hitWay, missWay, missVictimDirty, isRead;
  logic [indexW-1:0]   scanSet;
  logic                scanWay, scanDirty, lastScan;

  assign idx             = opAddr[indexW-1:0];
  assign tagIn           = opAddr[addrSize-1:indexW];
  assign hit0            = validArr[0][idx] && (tagArr[0][idx] == tagIn);
  assign hit1            = validArr[1][idx] && (tagArr[1][idx] == tagIn);
  assign hit             = hit0 || hit1;
  assign hitWay          = ~hit0;
  assign missWay         = !validArr[0][idx] ? 1'b0 : (!validArr[1][idx] ? 1'b1 : lruArr[idx]);
  assign missVictimDirty = validArr[missWay][idx] && dirtyArr[missWay][idx];
  assign isRead          = ptrPhase || (opCmd != cmdWrite);
  assign scanSet         = scanIdx[indexW:1];
  assign scanWay         = scanIdx[0];
  assign scanDirty       = validArr[scanWay][scanSet] && dirtyArr[scanWay][scanSet];
  assign lastScan        = &scanIdx;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and Moore outputs; RAM requests are pure functions of state so reset drops them at once
  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    dataReady = 1'b0;
    ramRdEn   = 1'b0;
    ramWrEn   = 1'b0;
    ramAddr   = '0;
    ramWData  = '0;
    case (state)
      IDLE:    if (start && cntrl != 2'b00) nextState = (cntrl == cmdFlush) ? FLSCAN : LOOKUP;
      LOOKUP: begin
        if (hit)                  nextState = ptrPhase ? RESOLVE : DONE;
        else if (missVictimDirty) nextState = EVICT;
        else                      nextState = isRead ? FILL : DONE;
      end
      EVICT: begin
        ramWrEn  = 1'b1;
        ramAddr  = {tagArr[victimWay][idx], idx};
        ramWData = dataArr[victimWay][idx];
        if (ramReady) nextState = isRead ? FILL : DONE;
      end
      FILL: begin
        ramRdEn = 1'b1;
        ramAddr = opAddr;
        if (ramReady) nextState = ptrPhase ? RESOLVE : DONE;
      end
      RESOLVE: nextState = LOOKUP;
      DONE: begin
        dataReady = 1'b1;
        nextState = IDLE;
      end
      FLSCAN: begin
        if (scanDirty)     nextState = FLWB;
        else if (lastScan) nextState = DONE;
      end
      FLWB: begin
        ramWrEn  = 1'b1;
        ramAddr  = {tagArr[scanWay][scanSet], scanSet};
        ramWData = dataArr[scanWay][scanSet];
        if (ramReady) nextState = lastScan ? DONE : FLSCAN;
      end
      default: nextState = IDLE;
    endcase
  end

  // Command latch, line status bits, counters and the read result
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      opCmd     <= '0;
      opAddr    <= '0;
      opData    <= '0;
      ptrPhase  <= 1'b0;
      ptrVal    <= '0;
      victimWay <= 1'b0;
      scanIdx   <= '0;
      dataOut   <= '0;
      hitCount  <= '0;
      missCount <= '0;
      for (int s = 0; s < numSets; s++) begin
        validArr[0][s] <= 1'b0;
        validArr[1][s] <= 1'b0;
        dirtyArr[0][s] <= 1'b0;
        dirtyArr[1][s] <= 1'b0;
        lruArr[s]      <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: if (start && cntrl != 2'b00) begin
          opCmd    <= cntrl;
          opAddr   <= addr;
          opData   <= dataIn;
          ptrPhase <= isIndirect && (cntrl != cmdFlush);
          scanIdx  <= '0;
        end
        LOOKUP: begin
          if (hit) begin
            if (hitCount != {cntW{1'b1}}) hitCount <= hitCount + 1'b1;
            lruArr[idx] <= ~hitWay;
            if (!isRead)      dirtyArr[hitWay][idx] <= 1'b1;
            else if (ptrPhase) ptrVal <= dataArr[hitWay][idx][addrSize-1:0];
            else               dataOut <= dataArr[hitWay][idx];
          end else begin
            if (missCount != {cntW{1'b1}}) missCount <= missCount + 1'b1;
            victimWay <= missWay;
            if (!missVictimDirty && !isRead) begin
              validArr[missWay][idx] <= 1'b1;
              dirtyArr[missWay][idx] <= 1'b1;
              lruArr[idx]            <= ~missWay;
            end
          end
        end
        EVICT: if (ramReady) begin
          // a write miss installs straight over the freshly cleaned victim
          dirtyArr[victimWay][idx] <= !isRead;
          if (!isRead) begin
            validArr[victimWay][idx] <= 1'b1;
            lruArr[idx]              <= ~victimWay;
          end
        end
        FILL: if (ramReady) begin
          validArr[victimWay][idx] <= 1'b1;
          dirtyArr[victimWay][idx] <= 1'b0;
          lruArr[idx]              <= ~victimWay;
          if (ptrPhase) ptrVal  <= ramRData[addrSize-1:0];
          else          dataOut <= ramRData;
        end
        RESOLVE: begin
          opAddr   <= ptrVal;
          ptrPhase <= 1'b0;
        end
        FLSCAN: if (!scanDirty) scanIdx <= scanIdx + 1'b1;
        FLWB: if (ramReady) begin
          dirtyArr[scanWay][scanSet] <= 1'b0;
          scanIdx                    <= scanIdx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && !isRead) begin
      dataArr[hitWay][idx] <= opData;
    end else if (state == LOOKUP && !hit && !missVictimDirty && !isRead) begin
      tagArr[missWay][idx]  <= tagIn;
      dataArr[missWay][idx] <= opData;
    end else if (state == EVICT && ramReady && !isRead) begin
      tagArr[victimWay][idx]  <= tagIn;
      dataArr[victimWay][idx] <= opData;
    end else if (state == FILL && ramReady) begin
      tagArr[victimWay][idx]  <= tagIn;
      dataArr[victimWay][idx] <= ramRData;
    end
  end
endmodule
